// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage with one-request-in-flight imem handshake, hold buffer and IF/ID register
//   in : clk, rst, stall, redirect_valid, redirect_pc[31:0], imem_ready, imem_rvalid, imem_rdata[31:0]
//   out: imem_req, imem_addr[31:0], inst_id[31:0], pc_id[31:0], valid_id
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        valid_id
);
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d, pc_req_q, pc_req_d;
  logic [31:0] buf_inst_q, buf_inst_d, buf_pc_q, buf_pc_d;
  logic [31:0] inst_q, inst_d, pc_id_q, pc_id_d;
  logic        buf_valid_q, buf_valid_d, valid_q, valid_d;
  logic        rsp;
  logic [31:0] redir;
  assign redir     = redirect_pc & ~32'd3;
  assign imem_req  = (state_q == FETCH) & ~buf_valid_q & ~redirect_valid & ~rst;
  assign imem_addr = pc_f_q;
  // only a response that arrives while waiting belongs to a live request
  assign rsp       = (state_q == WAIT) & imem_rvalid;
  assign inst_id   = inst_q;
  assign pc_id     = pc_id_q;
  assign valid_id  = valid_q;
  always_comb begin
    state_d     = state_q;
    pc_f_d      = redirect_valid ? redir : pc_f_q;
    pc_req_d    = pc_req_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    inst_d      = inst_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    case (state_q)
      FETCH: if (imem_req & imem_ready) begin
        pc_req_d = pc_f_q;
        pc_f_d   = pc_f_q + 32'd4;
        state_d  = WAIT;
      end
      WAIT:    state_d = imem_rvalid ? FETCH : (redirect_valid ? DRAIN : WAIT);
      DRAIN:   state_d = imem_rvalid ? FETCH : DRAIN;
      default: state_d = FETCH;
    endcase
    if (redirect_valid) begin
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (stall) begin
      if (rsp) begin
        buf_valid_d = 1'b1;
        buf_inst_d  = imem_rdata;
        buf_pc_d    = pc_req_q;
      end
    end else if (buf_valid_q) begin
      inst_d      = buf_inst_q;
      pc_id_d     = buf_pc_q;
      valid_d     = 1'b1;
      buf_valid_d = 1'b0;
    end else if (rsp) begin
      inst_d  = imem_rdata;
      pc_id_d = pc_req_q;
      valid_d = 1'b1;
    end else begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_f_q      <= RESET_PC;
      pc_req_q    <= 32'd0;
      buf_inst_q  <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_valid_q <= 1'b0;
      inst_q      <= NOP_INST;
      pc_id_q     <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      pc_req_q    <= pc_req_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_q      <= inst_d;
      pc_id_q     <= pc_id_d;
      valid_q     <= valid_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and randomized checks of inst_fetch_unit against a transaction-level model
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk, rst, stall, redirect_valid, imem_req, imem_ready, imem_rvalid, valid_id;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_id, pc_id;
  int vectors = 0, miscompares = 0;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'd1;
  endfunction
  // model: the fetch unit seen as at most one outstanding request that may be
  // cancelled by a redirect, a one-deep parking slot and the ID register
  logic [31:0] m_pc = 32'd0, m_fl_pc = 32'd0, m_buf_inst = 32'd0, m_buf_pc = 32'd0;
  logic [31:0] m_inst = NOP, m_pcid = 32'd0;
  logic        m_fl = 1'b0, m_dead = 1'b0, m_buf = 1'b0, m_v = 1'b0;
  always @(negedge clk) begin
    logic er, got, dlv;
    er = !rst && !m_fl && !m_buf && !redirect_valid;
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("inst_id", inst_id, m_inst);
    chk("pc_id", pc_id, m_pcid);
    chk("valid_id", {31'd0, valid_id}, {31'd0, m_v});
    if (rst) begin
      m_pc = 32'd0; m_fl = 0; m_dead = 0; m_buf = 0; m_inst = NOP; m_pcid = 32'd0; m_v = 0;
    end else begin
      got = imem_rvalid && m_fl;
      dlv = got && !m_dead && !redirect_valid;
      if (redirect_valid) begin
        m_inst = NOP; m_v = 0; m_buf = 0;
      end else if (stall) begin
        if (dlv) begin m_buf = 1; m_buf_inst = imem_rdata; m_buf_pc = m_fl_pc; end
      end else if (m_buf) begin
        m_inst = m_buf_inst; m_pcid = m_buf_pc; m_v = 1; m_buf = 0;
      end else if (dlv) begin
        m_inst = imem_rdata; m_pcid = m_fl_pc; m_v = 1;
      end else begin
        m_inst = NOP; m_v = 0;
      end
      if (got) m_fl = 0;
      else if (m_fl && redirect_valid) m_dead = 1;
      if (redirect_valid) m_pc = redirect_pc & ~32'd3;
      else if (er && imem_ready) begin m_fl = 1; m_dead = 0; m_fl_pc = m_pc; m_pc = m_pc + 32'd4; end
    end
  end
  // memory: one request at a time, response after 0..lat extra cycles
  logic        acc, mbusy = 1'b0;
  logic [31:0] acc_addr, maddr;
  int          mcnt, lat = 0;
  task automatic cycle();
    @(negedge clk);
    acc = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    #2;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (acc) begin mbusy = 1'b1; maddr = acc_addr; mcnt = $urandom_range(0, lat); end
    if (mbusy) begin
      if (mcnt == 0) begin imem_rvalid = 1'b1; imem_rdata = mem_word(maddr); mbusy = 1'b0; end
      else mcnt--;
    end
  endtask
  initial begin
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) cycle();
    rst = 0; #1;
    chk("reset req", {31'd0, imem_req}, 32'd1);
    chk("reset addr", imem_addr, 32'd0);
    chk("reset inst", inst_id, NOP);
    chk("reset valid", {31'd0, valid_id}, 32'd0);
    cycle();
    cycle(); #1;
    chk("first pc", pc_id, 32'd0);
    chk("first inst", inst_id, 32'd1);
    chk("first valid", {31'd0, valid_id}, 32'd1);
    chk("second addr", imem_addr, 32'd4);
    cycle(); #1;
    chk("bubble valid", {31'd0, valid_id}, 32'd0);
    chk("bubble inst", inst_id, NOP);
    cycle(); #1;
    chk("second pc", pc_id, 32'd4);
    chk("third addr", imem_addr, 32'd8);
    cycle(); stall = 1;
    cycle(); #1;
    chk("stall req", {31'd0, imem_req}, 32'd0);
    chk("stall hold pc", pc_id, 32'd4);
    cycle();
    cycle(); stall = 0;
    cycle(); #1;
    chk("buffered pc", pc_id, 32'd8);
    chk("buffered inst", inst_id, 32'd9);
    chk("after buf addr", imem_addr, 32'd12);
    cycle(); stall = 1;
    cycle(); redirect_valid = 1; redirect_pc = 32'h100;
    cycle(); stall = 0; redirect_valid = 0; lat = 2; #1;
    chk("flush valid", {31'd0, valid_id}, 32'd0);
    chk("flush inst", inst_id, NOP);
    chk("flush addr", imem_addr, 32'h100);
    cycle(); redirect_valid = 1; redirect_pc = 32'h202;
    cycle(); redirect_valid = 0; #1;
    chk("drain req", {31'd0, imem_req}, 32'd0);
    cycle();
    cycle(); imem_ready = 0; lat = 0; #1;
    chk("drain valid", {31'd0, valid_id}, 32'd0);
    chk("drain addr", imem_addr, 32'h200);
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      chk("ready low addr", imem_addr, 32'h200);
    end
    cycle(); imem_ready = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    cycle(); redirect_valid = 0; #1;
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    cycle(); lat = 2; #1;
    chk("wrapped addr", imem_addr, 32'd0);
    cycle(); rst = 1;
    cycle(); rst = 0; imem_ready = 0;
    cycle();
    cycle(); #1;
    chk("late rsp valid", {31'd0, valid_id}, 32'd0);
    chk("late rsp addr", imem_addr, 32'd0);
    imem_ready = 1; lat = 3;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      stall = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 255);
      imem_ready = ($urandom % 4) != 0;
    end
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
